// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR,
    S_CSUM
  } boot_state_t;

  localparam int BYTES_PER_INST = 4;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Collects bytes little-endian into a 32-bit word and flags the byte that completes it.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_complete
);

  localparam int IW = $clog2(BYTES_PER_INST);

  logic [IW-1:0] idx;
  logic [31:0]   word;

  // word_next already contains the byte being accepted, so the completed word is usable this cycle
  always_comb begin
    word_next = word;
    word_next[{idx, 3'b000} +: 8] = byte_in;
  end

  assign word_complete = byte_en && (idx == IW'(BYTES_PER_INST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (byte_en) begin
      idx  <= idx + IW'(1);
      word <= word_next;
    end
  end

endmodule

// File: rtl/instr_boot_loader.sv
// Loads a length-prefixed little-endian program into instruction memory and holds the core in reset until done.
// Optional trailing XOR checksum byte: define BOOT_CHECKSUM_EN.
module instr_boot_loader
  import boot_pkg::*;
#(
  parameter int NUM_INST   = 128,
  parameter int INST_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  localparam int AW        = addr_width(NUM_INST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [AW-1:0]         imem_addr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic [LEN_WIDTH-1:0]  inst_count,
  output logic                  core_rstn,
  output logic                  done,
  output logic                  err
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(NUM_INST);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t S_TAIL = S_CSUM;
`else
  localparam boot_state_t S_TAIL = S_DONE;
`endif

  boot_state_t          state, state_next;
  logic [7:0]           len_lo;
  logic [LEN_WIDTH-1:0] len, len_new;
  logic                 xfer, asm_en, word_complete;
  logic [31:0]          word_next;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
  // start wins over a concurrent byte; that byte is dropped
  assign xfer    = byte_valid && byte_ready && !start;
  assign asm_en  = xfer && (state == S_DATA);
  assign len_new = LEN_WIDTH'({byte_in, len_lo});

  boot_word_assembler u_asm (
    .clk           (clk),
    .rst           (rst),
    .clear         (start),
    .byte_en       (asm_en),
    .byte_in       (byte_in),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_LEN_LO;
    end else begin
      case (state)
        S_LEN_LO: if (xfer) state_next = S_LEN_HI;
        S_LEN_HI: if (xfer) begin
          if (len_new == '0)         state_next = S_TAIL;
          else if (len_new > MAX_LEN) state_next = S_ERR;
          else                        state_next = S_DATA;
        end
        S_DATA:   if (word_complete) state_next = S_WRITE;
        S_WRITE:  state_next = (inst_count + LEN_WIDTH'(1) == len) ? S_TAIL : S_DATA;
`ifdef BOOT_CHECKSUM_EN
        S_CSUM:   if (xfer) state_next = (byte_in == csum) ? S_DONE : S_ERR;
`endif
        default:  ;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      inst_count <= '0;
      core_rstn  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we   <= (state_next == S_WRITE);
      done      <= (state_next == S_DONE);
      err       <= (state_next == S_ERR);
      core_rstn <= (state_next == S_DONE);
      if (start) begin
        inst_count <= '0;
        imem_addr  <= '0;
`ifdef BOOT_CHECKSUM_EN
        csum       <= '0;
`endif
      end else begin
        if (xfer && state == S_LEN_LO) len_lo <= byte_in;
        if (xfer && state == S_LEN_HI) len <= len_new;
        if (word_complete) imem_wdata <= INST_WIDTH'(word_next);
        if (state == S_WRITE) begin
          imem_addr  <= imem_addr + AW'(1);
          inst_count <= inst_count + LEN_WIDTH'(1);
        end
`ifdef BOOT_CHECKSUM_EN
        if (asm_en) csum <= csum ^ byte_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_boot_loader.sv
// Self-checking bench for instr_boot_loader: directed sessions plus randomized programs against an array model.
module tb_instr_boot_loader;

  localparam int NUM_INST = 128;
  localparam int LW       = 16;
  localparam int AW       = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, imem_we, core_rstn, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [LW-1:0] inst_count;

  instr_boot_loader #(.NUM_INST(NUM_INST), .INST_WIDTH(32), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .inst_count (inst_count),
    .core_rstn  (core_rstn),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int gap_pct = 0;
  logic [31:0]      exp_mem [NUM_INST];
  logic [AW+31:0]   wr_q [$];

  always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  waited = 0;
    bit  acc = 1'b0;
    if (gap_pct > 0)
      while ($urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0;
        tick();
      end
    byte_valid = 1'b1;
    byte_in    = b;
    while (!acc && waited < 40) begin
      acc = byte_ready;
      tick();
      waited++;
    end
    byte_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NUM_INST; i++) exp_mem[i] = $urandom();
  endtask

  function automatic logic [7:0] model_csum(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) x ^= exp_mem[i][8*k +: 8];
    return x;
  endfunction

  task automatic load_program(input int n, input string tag, input bit do_start);
    int nw;
    wr_q.delete();
    if (do_start) pulse_start();
    check({tag, "_after_start"}, 64'({byte_ready, done, err, core_rstn, inst_count}),
          64'({1'b1, 3'b000, 16'd0}));
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        send_byte(exp_mem[i][8*k +: 8]);
        if (k == 3)
          check({tag, "_write"}, 64'({imem_we, imem_addr, imem_wdata}),
                64'({1'b1, AW'(i), exp_mem[i]}));
      end
`ifdef BOOT_CHECKSUM_EN
    send_byte(model_csum(n));
`else
    if (n > 0) tick();
`endif
    check({tag, "_done"}, 64'({done, core_rstn, err, byte_ready}), 64'(4'b1100));
    check({tag, "_count"}, 64'(inst_count), 64'(n));
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(n));
    nw = (wr_q.size() < n) ? wr_q.size() : n;
    for (int i = 0; i < nw; i++)
      check({tag, "_mem"}, 64'(wr_q[i]), 64'({AW'(i), exp_mem[i]}));
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs",
          64'({byte_ready, imem_we, imem_addr, imem_wdata, inst_count, core_rstn, done, err}), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_not_ready", 64'({byte_ready, done, err}), 64'(0));

    // Directed two-instruction program
    exp_mem[0] = 32'h00A00513;
    exp_mem[1] = 32'h00B00593;
    load_program(2, "directed", 1'b1);

    // Oversize length header: 0x0081 = 129 > NUM_INST
    wr_q.delete();
    pulse_start();
    send_byte(8'h81);
    send_byte(8'h00);
    check("oversize_state", 64'({err, done, core_rstn, byte_ready}), 64'(4'b1000));
    repeat (3) tick();
    check("oversize_sticky", 64'({err, core_rstn, byte_ready}), 64'(3'b100));
    check("oversize_nowrite", 64'(wr_q.size()), 64'(0));

    // Zero-length program
    load_program(0, "len0", 1'b1);

    // Largest legal program
    randomize_mem();
    load_program(NUM_INST, "full", 1'b1);

    // Asynchronous reset in the middle of the data phase
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h00);
    for (int k = 0; k < 3; k++) send_byte(8'(k + 8'h5A));
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs",
          64'({byte_ready, imem_we, imem_addr, imem_wdata, inst_count, core_rstn, done, err}), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    randomize_mem();
    load_program(3, "after_rst", 1'b1);

    // Restart in the middle of the third word with random valid gaps
    gap_pct = 50;
    randomize_mem();
    pulse_start();
    send_byte(8'h06);
    send_byte(8'h00);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom()));
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'hFF;
    tick();
    start      = 1'b0;
    byte_valid = 1'b0;
    check("restart_cleared", 64'({byte_ready, done, err, core_rstn, inst_count}),
          64'({1'b1, 3'b000, 16'd0}));
    randomize_mem();
    load_program(5, "restart", 1'b0);

    // Randomized programs of varying length
    for (int it = 0; it < 4; it++) begin
      randomize_mem();
      load_program(int'($urandom_range(10, 1)), "random", 1'b1);
    end
    gap_pct = 0;

`ifdef BOOT_CHECKSUM_EN
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0F);
    check("csum_good", 64'({done, err, core_rstn}), 64'(3'b101));
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    check("csum_bad", 64'({done, err, core_rstn}), 64'(3'b010));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_boot_loader.md
Name: instr_boot_loader

Overview:
- Upstream feeder for the single-cycle core. Receives a byte stream (valid/ready), assembles little-endian 32-bit instructions and writes them into instruction memory.
- Holds the core in reset (core_rstn low) until a complete, valid program is loaded, then releases it.
- Sits between the host byte link (UART RX or testbench) and the core's instruction memory write port and rstn input.

Parameters:
- NUM_INST, 128, instruction memory depth in words; addr width = $clog2(NUM_INST)
- INST_WIDTH, 32, instruction word width; must be 32 (4 bytes per word)
- LEN_WIDTH, 16, width of program-length header field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; begin/restart a load session
- byte_in  in  8  incoming data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader accepts byte this cycle (transfer = valid & ready)
- imem_we  out  1  instruction memory write enable, one cycle per word
- imem_addr  out  $clog2(NUM_INST)  word address
- imem_wdata  out  32  assembled instruction
- inst_count  out  LEN_WIDTH  words written in current session
- core_rstn  out  1  active-low reset to core; high only in DONE
- done  out  1  load complete (level)
- err  out  1  load aborted (level, sticky until start/rst)

Behaviour:
- Reset: state IDLE. byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, inst_count=0, core_rstn=0, done=0, err=0. Reset mid-session aborts immediately; memory contents are left as is.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0. start -> LEN_LO, with inst_count, byte index and address cleared.
- LEN_LO: byte_ready=1; on transfer, latch len[7:0] -> LEN_HI.
- LEN_HI: byte_ready=1; on transfer, latch len[15:8]:
  - len==0 -> DONE
  - len>NUM_INST -> ERR
  - otherwise -> DATA
- DATA: byte_ready=1. Byte k (0..3) is placed in wdata[8k+7:8k], little-endian. On the 4th transfer -> WRITE.
- WRITE: one cycle, byte_ready=0. imem_we=1, imem_addr=current word address, imem_wdata=assembled word. Next cycle: address+1, inst_count+1.
  - inst_count+1 == len -> DONE (or checksum state, see Optional Feature)
  - otherwise -> DATA
- DONE: done=1, core_rstn=1, byte_ready=0. Stays until start or rst.
- ERR: err=1, core_rstn=0, byte_ready=0. Stays until start or rst.
- start in any state: restart. Next state LEN_LO, done/err cleared, core_rstn=0 next cycle. start has priority over a simultaneous byte transfer; that byte is dropped.
- Throughput: at most one byte per cycle. Session length = 2 + 4*len transfers + len WRITE cycles. done rises the cycle after the last WRITE.
- byte_valid without byte_ready: byte is not consumed; the source must hold it.
- Address never wraps: len<=NUM_INST is checked before any write.
- All outputs are registered, except byte_ready, which is decoded from the state register.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined: adds state CSUM after the last WRITE (instead of DONE). One more byte is accepted and compared with the running XOR of all data bytes (header excluded). Equal -> DONE; unequal -> ERR. For len==0 the expected checksum is 0x00.
- Undefined: no CSUM state, no checksum byte; the flow goes straight to DONE.

Decomposition:
- Package boot_pkg:
  - state enum boot_state_t
  - BYTES_PER_INST = 4
  - localparam helper for address width
- One natural sub-module: boot_word_assembler. It holds the byte index counter and the 32-bit shift/assemble register, and flags word_complete. The FSM stays in instr_boot_loader.

Test Plan:
- rst high mid-DATA (after 5 bytes) -> all outputs return to reset values; start + full stream afterwards loads normally from addr 0.
- start; bytes 02 00, 13 05 A0 00, 93 05 B0 00 -> writes addr0=0x00A00513, addr1=0x00B00593; done=1 and core_rstn=1 one cycle after the 2nd WRITE; inst_count=2.
- start; len bytes 81 00 with NUM_INST=128 -> err=1, no imem_we, core_rstn stays 0, byte_ready=0.
- start; len 00 00 -> done=1 the cycle after the 2nd header byte; no writes.
- byte_valid toggled randomly 50% plus a start pulse in the middle of the 3rd word -> previous partial word discarded; after a new header, writes begin again at addr 0.
- BOOT_CHECKSUM_EN: len 01 00, data 01 02 04 08, checksum 0F -> done; checksum 0E -> err, core_rstn=0.
